// File: rtl/prog_logic_fn_pkg.sv
// Shared encodings for the programmable Boolean function unit.
// The mode helper turns a stored mask bit into a function value.
package prog_logic_fn_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_RUN  = 2'd2
  } state_e;

  localparam logic MODE_SOP = 1'b0;
  localparam logic MODE_POS = 1'b1;

  // A PoS mask marks the rows where f=0, so its bit is inverted.
  function automatic logic fn_apply_mode(input logic mask_bit, input logic mode);
    return mask_bit ^ mode;
  endfunction

endpackage

// File: rtl/prog_fn_cfg_loader.sv
// Serial truth-table loader: owns the mask, bit count, latched mode and the
// cfg_done / cfg_loaded status flags.
module prog_fn_cfg_loader
  import prog_logic_fn_pkg::*;
#(
  parameter int N_IN = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 cfg_start,
  input  logic                 cfg_mode,
  input  logic                 cfg_valid,
  input  logic                 cfg_bit,
  input  logic                 i_loading,
  output logic [2**N_IN-1:0]   o_mask,
  output logic                 o_mode,
  output logic                 o_last,
  output logic                 cfg_done,
  output logic                 cfg_loaded
);

  localparam logic [N_IN:0] LAST_IDX = (N_IN+1)'((2**N_IN) - 1);
  localparam logic [N_IN:0] ONE      = (N_IN+1)'(1);

  logic [2**N_IN-1:0] r_mask;
  logic [N_IN:0]      r_count;
  logic               r_mode;
  logic               r_done;
  logic               r_loaded;
  logic               w_accept;

  // cfg_start outranks cfg_valid, so a bit presented with it is dropped.
  assign w_accept = i_loading && cfg_valid && !cfg_start;
  assign o_last   = w_accept && (r_count == LAST_IDX);

  // Mask, counter and status registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_mask   <= '0;
      r_count  <= '0;
      r_mode   <= MODE_SOP;
      r_done   <= 1'b0;
      r_loaded <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (cfg_start) begin
        r_mask   <= '0;
        r_count  <= '0;
        r_mode   <= cfg_mode;
        r_loaded <= 1'b0;
      end else if (w_accept) begin
        r_mask[r_count[N_IN-1:0]] <= cfg_bit;
        r_count                   <= r_count + ONE;
        if (o_last) begin
          r_done   <= 1'b1;
          r_loaded <= 1'b1;
        end
      end
    end
  end

  assign o_mask     = r_mask;
  assign o_mode     = r_mode;
  assign cfg_done   = r_done;
  assign cfg_loaded = r_loaded;

endmodule

// File: rtl/prog_logic_fn.sv
// Runtime-programmable N-input Boolean function with a valid/ready
// evaluation stream and a one-entry registered output stage.
module prog_logic_fn
  import prog_logic_fn_pkg::*;
#(
  parameter int N_IN = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            cfg_start,
  input  logic            cfg_mode,
  input  logic            cfg_valid,
  input  logic            cfg_bit,
  output logic            cfg_done,
  output logic            cfg_loaded,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [N_IN-1:0] in_vec,
  output logic            out_valid,
  input  logic            out_ready,
  output logic            out_f,
  output logic [N_IN-1:0] out_idx
);

  state_e             r_state;
  state_e             w_state_next;
  logic [2**N_IN-1:0] w_mask;
  logic               w_mode;
  logic               w_last;
  logic               w_accept;
  logic               r_out_valid;
  logic               r_out_f;
  logic [N_IN-1:0]    r_out_idx;

  prog_fn_cfg_loader #(.N_IN(N_IN)) u_loader (
    .clk        (clk),
    .rst        (rst),
    .cfg_start  (cfg_start),
    .cfg_mode   (cfg_mode),
    .cfg_valid  (cfg_valid),
    .cfg_bit    (cfg_bit),
    .i_loading  (r_state == ST_LOAD),
    .o_mask     (w_mask),
    .o_mode     (w_mode),
    .o_last     (w_last),
    .cfg_done   (cfg_done),
    .cfg_loaded (cfg_loaded)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state logic.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE: begin
        if (cfg_start) w_state_next = ST_LOAD;
        else           w_state_next = ST_IDLE;
      end
      ST_LOAD: begin
        if (cfg_start)   w_state_next = ST_LOAD;
        else if (w_last) w_state_next = ST_RUN;
        else             w_state_next = ST_LOAD;
      end
      ST_RUN: begin
        if (cfg_start) w_state_next = ST_LOAD;
        else           w_state_next = ST_RUN;
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  // Combinational ready lets a full stage refill in the cycle it drains.
  assign in_ready = (r_state == ST_RUN) && (!r_out_valid || out_ready);
  assign w_accept = in_valid && in_ready;

  // Output stage: load on accept, clear on consume, otherwise hold.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_out_valid <= 1'b0;
      r_out_f     <= 1'b0;
      r_out_idx   <= '0;
    end else if (w_accept) begin
      r_out_valid <= 1'b1;
      r_out_f     <= fn_apply_mode(w_mask[in_vec], w_mode);
      r_out_idx   <= in_vec;
    end else if (out_ready) begin
      r_out_valid <= 1'b0;
    end else begin
      r_out_valid <= r_out_valid;
    end
  end

  assign out_valid = r_out_valid;
  assign out_f     = r_out_f;
  assign out_idx   = r_out_idx;

endmodule

// File: tb/tb_prog_logic_fn.sv
// Directed self-checking bench for prog_logic_fn at N_IN=4 and N_IN=2.
module tb_prog_logic_fn;
  import prog_logic_fn_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  logic       cfg_start, cfg_mode, cfg_valid, cfg_bit;
  logic       cfg_done, cfg_loaded;
  logic       in_valid, in_ready, out_valid, out_ready, out_f;
  logic [3:0] in_vec, out_idx;

  logic       b_cfg_start, b_cfg_mode, b_cfg_valid, b_cfg_bit;
  logic       b_cfg_done, b_cfg_loaded;
  logic       b_in_valid, b_in_ready, b_out_valid, b_out_ready, b_out_f;
  logic [1:0] b_in_vec, b_out_idx;

  int n_checks = 0;
  int n_fail   = 0;

  logic [15:0] tbl     = 16'h8047;
  logic [7:0]  pos_exp = 8'b1011_1000;
  logic [3:0]  and_tbl = 4'b1000;

  always #5 clk = ~clk;

  prog_logic_fn #(.N_IN(4)) dut (
    .clk(clk), .rst(rst), .cfg_start(cfg_start), .cfg_mode(cfg_mode),
    .cfg_valid(cfg_valid), .cfg_bit(cfg_bit), .cfg_done(cfg_done),
    .cfg_loaded(cfg_loaded), .in_valid(in_valid), .in_ready(in_ready),
    .in_vec(in_vec), .out_valid(out_valid), .out_ready(out_ready),
    .out_f(out_f), .out_idx(out_idx)
  );

  prog_logic_fn #(.N_IN(2)) dut2 (
    .clk(clk), .rst(rst), .cfg_start(b_cfg_start), .cfg_mode(b_cfg_mode),
    .cfg_valid(b_cfg_valid), .cfg_bit(b_cfg_bit), .cfg_done(b_cfg_done),
    .cfg_loaded(b_cfg_loaded), .in_valid(b_in_valid), .in_ready(b_in_ready),
    .in_vec(b_in_vec), .out_valid(b_out_valid), .out_ready(b_out_ready),
    .out_f(b_out_f), .out_idx(b_out_idx)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic start(input logic mode);
    cfg_start = 1'b1;
    cfg_mode  = mode;
    tick();
    cfg_start = 1'b0;
  endtask

  task automatic feed(input logic [15:0] m, input int first, input int last);
    for (int i = first; i <= last; i++) begin
      cfg_valid = 1'b1;
      cfg_bit   = m[i];
      tick();
    end
    cfg_valid = 1'b0;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    cfg_start = 1'b0; cfg_mode = 1'b0; cfg_valid = 1'b0; cfg_bit = 1'b0;
    in_valid = 1'b0; in_vec = 4'd0; out_ready = 1'b1;
    b_cfg_start = 1'b0; b_cfg_mode = 1'b0; b_cfg_valid = 1'b0; b_cfg_bit = 1'b0;
    b_in_valid = 1'b0; b_in_vec = 2'd0; b_out_ready = 1'b1;
    tick();
    tick();
    check("rst_done",    32'(cfg_done),   32'd0);
    check("rst_loaded",  32'(cfg_loaded), 32'd0);
    check("rst_ready",   32'(in_ready),   32'd0);
    check("rst_ovalid",  32'(out_valid),  32'd0);
    check("rst_of",      32'(out_f),      32'd0);
    check("rst_oidx",    32'(out_idx),    32'd0);
    check("rst2_loaded", 32'(b_cfg_loaded), 32'd0);
    rst = 1'b0;

    // PoS load and stream
    start(MODE_POS);
    check("pos_loaded_low", 32'(cfg_loaded), 32'd0);
    feed(tbl, 0, 14);
    check("pos_done_early", 32'(cfg_done), 32'd0);
    feed(tbl, 15, 15);
    check("pos_done",   32'(cfg_done),   32'd1);
    check("pos_loaded", 32'(cfg_loaded), 32'd1);
    tick();
    check("pos_done_1cyc", 32'(cfg_done), 32'd0);
    for (int i = 0; i < 8; i++) begin
      in_valid = 1'b1;
      in_vec   = 4'(i);
      tick();
      check("pos_stream_v", 32'(out_valid), 32'd1);
      check("pos_stream_i", 32'(out_idx),   32'(i));
      check("pos_stream_f", 32'(out_f),     32'(pos_exp[i]));
    end
    in_vec = 4'd15; tick(); check("pos_f15", 32'(out_f), 32'd0);
    in_vec = 4'd8;  tick(); check("pos_f8",  32'(out_f), 32'd1);
    in_valid = 1'b0;
    tick();
    check("pos_drain", 32'(out_valid), 32'd0);

    // Backpressure
    out_ready = 1'b0; in_valid = 1'b1; in_vec = 4'd3;
    #1 check("bp_ready0", 32'(in_ready), 32'd1);
    tick();
    check("bp_first_i", 32'(out_idx), 32'd3);
    check("bp_first_f", 32'(out_f),   32'd1);
    in_vec = 4'd6;
    for (int k = 0; k < 3; k++) begin
      #1 check("bp_stall_ready", 32'(in_ready), 32'd0);
      tick();
      check("bp_hold_v", 32'(out_valid), 32'd1);
      check("bp_hold_i", 32'(out_idx),   32'd3);
      check("bp_hold_f", 32'(out_f),     32'd1);
    end
    out_ready = 1'b1;
    #1 check("bp_release_ready", 32'(in_ready), 32'd1);
    tick();
    check("bp_next_i", 32'(out_idx), 32'd6);
    check("bp_next_f", 32'(out_f),   32'd0);
    in_valid = 1'b0;
    tick();
    check("bp_empty", 32'(out_valid), 32'd0);

    // Pending output across restart, restart priority, SoP reload
    out_ready = 1'b0; in_valid = 1'b1; in_vec = 4'd7;
    tick();
    in_valid = 1'b0;
    start(MODE_SOP);
    check("rs_loaded_low", 32'(cfg_loaded), 32'd0);
    check("rs_pend_v",     32'(out_valid),  32'd1);
    check("rs_pend_i",     32'(out_idx),    32'd7);
    check("rs_pend_f",     32'(out_f),      32'd1);
    check("rs_no_ready",   32'(in_ready),   32'd0);
    feed(16'h007F, 0, 6);
    cfg_start = 1'b1; cfg_mode = MODE_SOP; cfg_valid = 1'b1; cfg_bit = 1'b1;
    tick();
    cfg_start = 1'b0; cfg_valid = 1'b0;
    out_ready = 1'b1;
    tick();
    check("rs_drained", 32'(out_valid), 32'd0);
    feed(tbl, 0, 14);
    check("rs_done_early", 32'(cfg_done), 32'd0);
    feed(tbl, 15, 15);
    check("rs_done", 32'(cfg_done), 32'd1);
    in_valid = 1'b1;
    in_vec = 4'd0;  tick(); check("sop_f0",  32'(out_f), 32'd1);
    in_vec = 4'd3;  tick(); check("sop_f3",  32'(out_f), 32'd0);
    in_vec = 4'd15; tick(); check("sop_f15", 32'(out_f), 32'd1);
    in_valid = 1'b0;
    tick();

    // Reset mid-load
    start(MODE_POS);
    feed(tbl, 0, 4);
    rst = 1'b1; tick(); rst = 1'b0;
    check("rl_loaded", 32'(cfg_loaded), 32'd0);
    check("rl_done",   32'(cfg_done),   32'd0);
    check("rl_ready",  32'(in_ready),   32'd0);
    check("rl_ovalid", 32'(out_valid),  32'd0);

    // Reset with a pending output
    start(MODE_POS);
    feed(tbl, 0, 15);
    tick();
    out_ready = 1'b0; in_valid = 1'b1; in_vec = 4'd9;
    tick();
    check("ro_pend_v", 32'(out_valid), 32'd1);
    rst = 1'b1; tick(); rst = 1'b0;
    out_ready = 1'b1;
    check("ro_ovalid", 32'(out_valid),  32'd0);
    check("ro_of",     32'(out_f),      32'd0);
    check("ro_oidx",   32'(out_idx),    32'd0);
    check("ro_loaded", 32'(cfg_loaded), 32'd0);
    check("ro_done",   32'(cfg_done),   32'd0);
    for (int k = 0; k < 3; k++) begin
      check("ro_ready_idle", 32'(in_ready), 32'd0);
      tick();
      check("ro_ignored", 32'(out_valid), 32'd0);
    end
    in_valid = 1'b0;
    start(MODE_POS);
    feed(tbl, 0, 15);
    in_valid = 1'b1; in_vec = 4'd8;
    tick();
    check("ro_reload_i", 32'(out_idx), 32'd8);
    check("ro_reload_f", 32'(out_f),   32'd1);
    in_valid = 1'b0;
    tick();

    // N_IN=2 AND function
    b_cfg_start = 1'b1; b_cfg_mode = MODE_SOP;
    tick();
    b_cfg_start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      b_cfg_valid = 1'b1;
      b_cfg_bit   = and_tbl[i];
      tick();
      check("and_done", 32'(b_cfg_done), 32'(i == 3));
    end
    b_cfg_valid = 1'b0;
    for (int v = 0; v < 4; v++) begin
      b_in_valid = 1'b1;
      b_in_vec   = 2'(v);
      tick();
      check("and_idx", 32'(b_out_idx), 32'(v));
      check("and_f",   32'(b_out_f),   32'(v == 3));
    end
    b_in_valid = 1'b0;
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
